// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_ctrl_pkg
//  Purpose  : Shared types and helpers for the 1x1 convolution tile
//             controller: FSM state encoding, default lane geometry and a
//             ceiling-divide helper used to derive the filter-tile count.
//  Ports    : none (package)
//  Revision : 1.0  initial parametrised release
// ============================================================================
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEF_LANE  = 4;
    localparam int LANE_LOG2 = $clog2(DEF_LANE);

    // Ceiling division; the divisor is always an elaboration-time constant
    // at the call site, so this reduces to constant-divisor logic.
    function automatic logic [31:0] ceil_div(input logic [31:0] num,
                                             input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv1x1_tile_controller_loop_counter.sv
`default_nettype none
// ============================================================================
//  Module   : loop_counter
//  Purpose  : One loop level of the convolution walk. Counts 0..limit_i,
//             advancing on en_i; wrap_o flags the advance that returns to 0
//             so the next-outer level can be chained from it.
//  Ports    : clk, reset   - clock, synchronous active-high reset
//             clr_i        - synchronous clear (job start)
//             en_i         - advance this cycle
//             limit_i      - last count value (trip count - 1)
//             count_o      - current count
//             wrap_o       - en_i asserted while count_o == limit_i
//  Revision : 1.0  initial release
// ============================================================================
module loop_counter #(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] limit_i,
    output logic [DIM_W-1:0] count_o,
    output logic             wrap_o
);

    logic [DIM_W-1:0] count_q;

    assign wrap_o  = en_i && (count_q == limit_i);
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= wrap_o ? '0 : count_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv1x1_tile_controller.sv
`default_nettype none
// ============================================================================
//  Module   : conv1x1_tile_controller
//  Purpose  : Address/strobe sequencer for a 1x1 convolution on an NUM_PE
//             wide PE array. Walks pixel (outer) x filter tile x channel word
//             (inner), one fetch per accepted cycle, with per-PE accumulator
//             clear/finish strobes and an OFM write one cycle after finish.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             cal_start             - job start pulse (honoured in IDLE only)
//             weight_c/num_filter/num_pixel - job geometry, latched at start
//             data_ready            - buffers accept a fetch (0 = stall)
//             fetch_en, addr_ifm, addr_weight - fetch strobe and addresses
//             addr_ofm, ofm_we      - OFM write of a finished (pixel, tile)
//             PE_reset, PE_finish   - per-PE accumulator clear / complete
//             busy, done, cfg_err   - job status
//  Revision : 1.0  initial parametrised release
// ============================================================================
module conv1x1_tile_controller
    import conv_ctrl_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int LANE   = 4,
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cal_start,
    input  logic [DIM_W-1:0]  weight_c,
    input  logic [DIM_W-1:0]  num_filter,
    input  logic [DIM_W-1:0]  num_pixel,
    input  logic              data_ready,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] addr_ifm,
    output logic [ADDR_W-1:0] addr_weight,
    output logic [ADDR_W-1:0] addr_ofm,
    output logic              ofm_we,
    output logic [NUM_PE-1:0] PE_reset,
    output logic [NUM_PE-1:0] PE_finish,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_t            state_q;
    logic [DIM_W-1:0]  cw_m1_q, ft_m1_q, np_m1_q, rem_q;
    logic [ADDR_W-1:0] cw_a_q;
    logic [ADDR_W-1:0] ifm_base_q, w_base_q, ofm_cnt_q, ofm_pend_q;
    logic              ofm_pend_vld_q;

    logic              fetch_en_q, ofm_we_q, busy_q, done_q, cfg_err_q;
    logic [ADDR_W-1:0] addr_ifm_q, addr_weight_q, addr_ofm_q;
    logic [NUM_PE-1:0] pe_reset_q, pe_finish_q;

    logic [DIM_W-1:0]  w_c, w_ft, w_p;
    logic              w_c_wrap, w_ft_wrap, w_p_wrap;
    logic              w_go, w_start, w_cfg_ok;
    logic [DIM_W-1:0]  w_cw, w_ft_cnt, w_rem;
    logic [NUM_PE-1:0] w_fin_mask;

    // ---------------- configuration decode ----------------
    assign w_cfg_ok = (weight_c != '0) && ((weight_c % DIM_W'(LANE)) == '0) &&
                      (num_filter != '0) && (num_pixel != '0);
    assign w_cw     = weight_c / DIM_W'(LANE);
    assign w_ft_cnt = DIM_W'(ceil_div(32'(num_filter), 32'(NUM_PE)));
    assign w_rem    = num_filter % DIM_W'(NUM_PE);

    assign w_start  = (state_q == S_IDLE) && cal_start && w_cfg_ok;
    assign w_go     = (state_q == S_FETCH) && data_ready;

    // Partial last tile only finishes the PEs that hold real filters.
    assign w_fin_mask = ((w_ft == ft_m1_q) && (rem_q != '0)) ?
                        ~({NUM_PE{1'b1}} << rem_q) : {NUM_PE{1'b1}};

    // ---------------- loop nest: c (inner) -> ft -> p (outer) ----------------
    loop_counter #(.DIM_W(DIM_W)) u_cnt_c (
        .clk(clk), .reset(reset), .clr_i(w_start), .en_i(w_go),
        .limit_i(cw_m1_q), .count_o(w_c), .wrap_o(w_c_wrap)
    );

    loop_counter #(.DIM_W(DIM_W)) u_cnt_ft (
        .clk(clk), .reset(reset), .clr_i(w_start), .en_i(w_c_wrap),
        .limit_i(ft_m1_q), .count_o(w_ft), .wrap_o(w_ft_wrap)
    );

    loop_counter #(.DIM_W(DIM_W)) u_cnt_p (
        .clk(clk), .reset(reset), .clr_i(w_start), .en_i(w_ft_wrap),
        .limit_i(np_m1_q), .count_o(w_p), .wrap_o(w_p_wrap)
    );

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cw_m1_q        <= '0;
            ft_m1_q        <= '0;
            np_m1_q        <= '0;
            rem_q          <= '0;
            cw_a_q         <= '0;
            ifm_base_q     <= '0;
            w_base_q       <= '0;
            ofm_cnt_q      <= '0;
            ofm_pend_q     <= '0;
            ofm_pend_vld_q <= 1'b0;
            fetch_en_q     <= 1'b0;
            addr_ifm_q     <= '0;
            addr_weight_q  <= '0;
            addr_ofm_q     <= '0;
            ofm_we_q       <= 1'b0;
            pe_reset_q     <= '0;
            pe_finish_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            fetch_en_q     <= 1'b0;
            pe_reset_q     <= '0;
            pe_finish_q    <= '0;
            ofm_we_q       <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            ofm_pend_vld_q <= 1'b0;

            // The OFM write trails its PE_finish by one cycle regardless of
            // what the fetch side is doing (stall or job end).
            if (ofm_pend_vld_q) begin
                ofm_we_q   <= 1'b1;
                addr_ofm_q <= ofm_pend_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (cal_start) begin
                        if (w_cfg_ok) begin
                            cw_m1_q    <= w_cw - 1'b1;
                            ft_m1_q    <= w_ft_cnt - 1'b1;
                            np_m1_q    <= num_pixel - 1'b1;
                            rem_q      <= w_rem;
                            cw_a_q     <= ADDR_W'(w_cw);
                            ifm_base_q <= '0;
                            w_base_q   <= '0;
                            ofm_cnt_q  <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            cfg_err_q  <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (data_ready) begin
                        fetch_en_q    <= 1'b1;
                        addr_ifm_q    <= ifm_base_q + ADDR_W'(w_c);
                        addr_weight_q <= w_base_q + ADDR_W'(w_c);
                        pe_reset_q    <= (w_c == '0) ? {NUM_PE{1'b1}} : '0;
                        if (w_c_wrap) begin
                            pe_finish_q    <= w_fin_mask;
                            ofm_pend_vld_q <= 1'b1;
                            ofm_pend_q     <= ofm_cnt_q;
                            // Running p*FT+ft index: one step per finished tile.
                            ofm_cnt_q      <= ofm_cnt_q + 1'b1;
                            w_base_q       <= w_ft_wrap ? '0 : w_base_q + cw_a_q;
                        end
                        if (w_ft_wrap) begin
                            ifm_base_q <= ifm_base_q + cw_a_q;
                        end
                        if (w_p_wrap) begin
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_en    = fetch_en_q;
    assign addr_ifm    = addr_ifm_q;
    assign addr_weight = addr_weight_q;
    assign addr_ofm    = addr_ofm_q;
    assign ofm_we      = ofm_we_q;
    assign PE_reset    = pe_reset_q;
    assign PE_finish   = pe_finish_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv1x1_tile_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv1x1_tile_controller
//  Purpose  : Self-checking bench for conv1x1_tile_controller. A behavioural
//             model expands each job into its expected fetch list with plain
//             loop arithmetic and is stepped once per clock edge alongside
//             the DUT; every output is compared each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv1x1_tile_controller;

    localparam int NUM_PE = 4;
    localparam int LANE   = 4;
    localparam int DIM_W  = 16;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              cal_start;
    logic [DIM_W-1:0]  weight_c, num_filter, num_pixel;
    logic              data_ready;
    logic              fetch_en, ofm_we, busy, done, cfg_err;
    logic [ADDR_W-1:0] addr_ifm, addr_weight, addr_ofm;
    logic [NUM_PE-1:0] PE_reset, PE_finish;

    conv1x1_tile_controller #(
        .NUM_PE(NUM_PE), .LANE(LANE), .DIM_W(DIM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .cal_start(cal_start),
        .weight_c(weight_c), .num_filter(num_filter), .num_pixel(num_pixel),
        .data_ready(data_ready), .fetch_en(fetch_en), .addr_ifm(addr_ifm),
        .addr_weight(addr_weight), .addr_ofm(addr_ofm), .ofm_we(ofm_we),
        .PE_reset(PE_reset), .PE_finish(PE_finish), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ifm;
        int w;
        int rst;
        int fin;
        int ofm;
    } fetch_t;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_END  = 2;

    fetch_t exp_q[$];
    int     phase      = PH_IDLE;
    int     m_ifm      = 0;
    int     m_w        = 0;
    int     m_aofm     = 0;
    bit     m_fin_pend = 0;
    int     m_ofm_pend = 0;

    // Expand a job into its fetch list straight from the loop definition.
    task automatic build_job(input int wc, input int nf, input int np);
        int cw, ft_n, rem, full;
        fetch_t r;
        cw   = wc / LANE;
        ft_n = (nf + NUM_PE - 1) / NUM_PE;
        rem  = nf % NUM_PE;
        full = (1 << NUM_PE) - 1;
        exp_q.delete();
        for (int p = 0; p < np; p++)
            for (int ft = 0; ft < ft_n; ft++)
                for (int c = 0; c < cw; c++) begin
                    r.ifm = p * cw + c;
                    r.w   = ft * cw + c;
                    r.rst = (c == 0) ? full : 0;
                    if (c != cw - 1)                      r.fin = 0;
                    else if (ft == ft_n - 1 && rem != 0)  r.fin = (1 << rem) - 1;
                    else                                  r.fin = full;
                    r.ofm = p * ft_n + ft;
                    exp_q.push_back(r);
                end
    endtask

    // One clock: apply inputs, take the edge, advance model, compare.
    task automatic cycle(input logic dr, input logic st, input logic [15:0] wc,
                         input logic [15:0] nf, input logic [15:0] np,
                         input logic rs);
        bit e_fe, e_done, e_cfg, e_ofm, e_busy, chk_addr;
        int e_rst, e_fin;
        fetch_t r;
        data_ready = dr; cal_start = st; weight_c = wc;
        num_filter = nf; num_pixel = np; reset = rs;
        @(posedge clk);
        #1;
        e_fe = 0; e_done = 0; e_cfg = 0; e_rst = 0; e_fin = 0;
        e_ofm = m_fin_pend;
        if (e_ofm) m_aofm = m_ofm_pend;
        m_fin_pend = 0;
        chk_addr = (phase == PH_RUN);
        if (rs) begin
            phase = PH_IDLE; m_ifm = 0; m_w = 0; m_aofm = 0;
            e_ofm = 0; chk_addr = 1; exp_q.delete();
        end else begin
            case (phase)
                PH_IDLE: if (st) begin
                    if (wc == 0 || (wc % LANE) != 0 || nf == 0 || np == 0)
                        e_cfg = 1;
                    else begin
                        build_job(wc, nf, np);
                        phase = PH_RUN;
                    end
                end
                PH_RUN: if (dr) begin
                    r = exp_q.pop_front();
                    e_fe = 1; m_ifm = r.ifm; m_w = r.w;
                    e_rst = r.rst; e_fin = r.fin;
                    if (r.fin != 0) begin
                        m_fin_pend = 1; m_ofm_pend = r.ofm;
                    end
                    if (exp_q.size() == 0) phase = PH_END;
                end
                default: begin
                    e_done = 1; phase = PH_IDLE;
                end
            endcase
        end
        e_busy = (phase != PH_IDLE);
        check("fetch_en",  64'(fetch_en),  64'(e_fe));
        check("busy",      64'(busy),      64'(e_busy));
        check("done",      64'(done),      64'(e_done));
        check("cfg_err",   64'(cfg_err),   64'(e_cfg));
        check("ofm_we",    64'(ofm_we),    64'(e_ofm));
        check("PE_reset",  64'(PE_reset),  64'(e_rst));
        check("PE_finish", 64'(PE_finish), 64'(e_fin));
        if (chk_addr) begin
            check("addr_ifm",    64'(addr_ifm),    64'(m_ifm));
            check("addr_weight", 64'(addr_weight), 64'(m_w));
        end
        if (e_ofm || rs)
            check("addr_ofm", 64'(addr_ofm), 64'(m_aofm));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'd16, 16'd8, 16'd2, 1'b0);
    endtask

    // mode 0: no stall, 1: random stall, 2: three-cycle stall mid-tile.
    // Config inputs are scrambled while running to prove they are latched.
    task automatic run_job(input logic [15:0] wc, input logic [15:0] nf,
                           input logic [15:0] np, input int mode);
        logic dr;
        int   i;
        cycle(1'b1, 1'b1, wc, nf, np, 1'b0);
        i = 0;
        while (phase != PH_IDLE && i < 4000) begin
            if (mode == 0)      dr = 1'b1;
            else if (mode == 1) dr = ($urandom_range(0, 3) != 0);
            else                dr = !(i >= 5 && i < 8);
            cycle(dr, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            i++;
        end
        if (i >= 4000) check("job_bound", 64'(i), 64'(0));
    endtask

    initial begin
        data_ready = 1'b0; cal_start = 1'b0; reset = 1'b1;
        weight_c = '0; num_filter = '0; num_pixel = '0;

        cycle(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
        cycle(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
        idle(2);

        run_job(16'd16, 16'd8, 16'd2, 0);   // 16 fetches, 4 OFM writes
        idle(1);
        run_job(16'd16, 16'd6, 16'd2, 0);   // partial last tile
        idle(1);
        run_job(16'd4, 16'd4, 16'd3, 0);    // CW=1: reset and finish coincide
        idle(1);
        run_job(16'd16, 16'd8, 16'd2, 2);   // three-cycle stall mid-tile
        idle(1);

        run_job(16'd6, 16'd8, 16'd2, 0);    // bad weight_c
        idle(2);
        run_job(16'd16, 16'd8, 16'd0, 0);   // zero pixels
        idle(2);
        run_job(16'd0, 16'd8, 16'd2, 0);
        idle(2);
        run_job(16'd8, 16'd0, 16'd2, 0);
        idle(2);

        // back-to-back jobs: start in the cycle done is visible
        run_job(16'd8, 16'd5, 16'd2, 0);
        run_job(16'd12, 16'd3, 16'd1, 1);
        idle(1);

        // reset mid-job aborts it, then a full job runs from address 0
        cycle(1'b1, 1'b1, 16'd16, 16'd8, 16'd2, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        cycle(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
        idle(2);
        run_job(16'd16, 16'd8, 16'd2, 0);
        idle(1);

        // randomized jobs with random stalls and occasional bad configs
        for (int j = 0; j < 25; j++) begin
            logic [15:0] wc, nf, np;
            wc = 16'(LANE * $urandom_range(0, 5) + (($urandom_range(0, 7) == 0) ? 1 : 0));
            nf = 16'($urandom_range(0, 11));
            np = 16'($urandom_range(1, 4));
            run_job(wc, nf, np, int'($urandom_range(0, 1)));
            idle(int'($urandom_range(1, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
